// File: rtl/fifo_rptr_ctrl.sv
// Read-side pointer controller for a dual-clock FIFO: binary/Gray read pointers,
// registered empty/almost-empty flags, occupancy count, sticky underflow and flush.
module fifo_rptr_ctrl #(
    parameter int PTR_WIDTH     = 3,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk_r,
    input  logic                 arst,
    input  logic                 r_en,
    input  logic                 flush,
    input  logic                 clr_err,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic [PTR_WIDTH-1:0] r_addr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 underflow
);

    localparam int                 PW1       = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AE_THRESH = PW1'(AEMPTY_THRESH);

    generate
        if (PTR_WIDTH < 1 || AEMPTY_THRESH < 0 || AEMPTY_THRESH > (2 ** PTR_WIDTH)) begin : g_param_check
            $error("fifo_rptr_ctrl: PTR_WIDTH must be >= 1 and AEMPTY_THRESH within 0..2**PTR_WIDTH");
        end
    endgenerate

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] b_wptr;
    logic               rd_fire;
    logic               uf_set;
    logic [PTR_WIDTH:0] b_rptr_next;
    logic [PTR_WIDTH:0] g_rptr_next;
    logic [PTR_WIDTH:0] count_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        b_wptr      = gray2bin(g_wptr_sync);
        rd_fire     = r_en & ~empty & ~flush;
        uf_set      = r_en & empty & ~flush;
        b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, rd_fire};
        if (flush) begin
            b_rptr_next = b_wptr;
        end
        g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
        // Modular difference: full depth reads as 2**PTR_WIDTH, never aliasing to 0.
        count_next  = b_wptr - b_rptr_next;
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_r) begin
        if (arst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            b_rptr       <= b_rptr_next;
            g_rptr       <= g_rptr_next;
            empty        <= (g_rptr_next == g_wptr_sync);
            rd_count     <= count_next;
            almost_empty <= (count_next <= AE_THRESH);
            // Set beats clear when both land in the same cycle.
            if (uf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    assign r_addr = b_rptr[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rptr_ctrl.sv
// Self-checking bench for fifo_rptr_ctrl (PTR_WIDTH=3, AEMPTY_THRESH=2): directed scenarios
// plus randomized traffic, all compared against an occupancy-level reference model.
module tb_fifo_rptr_ctrl;

    localparam int PW    = 3;
    localparam int MOD   = 16;
    localparam int DEPTH = 8;
    localparam int AE    = 2;

    logic          clk_r = 1'b0;
    logic          arst;
    logic          r_en;
    logic          flush;
    logic          clr_err;
    logic [PW:0]   wp;
    logic [PW:0]   g_wptr_sync;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic [PW-1:0] r_addr;
    logic          empty;
    logic          almost_empty;
    logic [PW:0]   rd_count;
    logic          underflow;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: read position and occupancy as plain integers.
    int m_rp;
    int m_count;
    bit m_empty;
    bit m_ae;
    bit m_uf;

    assign g_wptr_sync = wp ^ (wp >> 1);

    fifo_rptr_ctrl #(.PTR_WIDTH(PW), .AEMPTY_THRESH(AE)) dut (
        .clk_r        (clk_r),
        .arst         (arst),
        .r_en         (r_en),
        .flush        (flush),
        .clr_err      (clr_err),
        .g_wptr_sync  (g_wptr_sync),
        .b_rptr       (b_rptr),
        .g_rptr       (g_rptr),
        .r_addr       (r_addr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .underflow    (underflow)
    );

    always #5 clk_r = ~clk_r;

    function automatic logic [17:0] exp_vec();
        logic [PW:0] rp;
        rp = 4'(m_rp);
        return {rp, rp ^ (rp >> 1), rp[PW-1:0], m_empty, m_ae, 4'(m_count), m_uf};
    endfunction

    function automatic logic [17:0] act_vec();
        return {b_rptr, g_rptr, r_addr, empty, almost_empty, rd_count, underflow};
    endfunction

    task automatic model_step();
        bit fire;
        if (arst) begin
            m_rp = 0; m_count = 0; m_empty = 1; m_ae = 1; m_uf = 0;
        end else begin
            fire = r_en && !m_empty && !flush;
            if (r_en && m_empty && !flush) m_uf = 1;
            else if (clr_err)              m_uf = 0;
            m_rp    = flush ? int'(wp) : (m_rp + int'(fire)) % MOD;
            m_count = (int'(wp) - m_rp + MOD) % MOD;
            m_empty = (m_count == 0);
            m_ae    = (m_count <= AE);
        end
    endtask

    // Advance one edge, update the model with the inputs seen at that edge, settle.
    task automatic tick();
        @(posedge clk_r);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit a, input bit r, input bit f, input bit c, input int w);
        arst = a; r_en = r; flush = f; clr_err = c; wp = 4'(w);
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 0, 4);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (act_vec() !== exp_vec() || act_vec() !== 18'b0000_0000_000_1_1_0000_0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h required %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_fill_drain();
        set_in(0, 0, 0, 0, 4);
        tick();
        vectors++;
        if (rd_count !== 4'd4 || empty !== 1'b0 || almost_empty !== 1'b0 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL fill: got %h required %h", act_vec(), exp_vec());
        end
        r_en = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (act_vec() !== exp_vec() || b_rptr !== 4'((i > 4) ? 4 : i)) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h required %h", i, act_vec(), exp_vec());
            end
        end
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_underflow: got %b required 1", underflow);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        int tgt;
        r_en = 1;
        while (m_rp != 15 && guard < 64) begin
            tgt = (m_rp + 3 > 15) ? 15 : m_rp + 3;
            if (tgt > int'(wp)) wp = 4'(tgt);
            tick();
            guard++;
            vectors++;
            if (act_vec() !== exp_vec() || rd_count > 4'(DEPTH)) begin
                miscompares++;
                $display("FAIL wrap_drain: got %h required %h", act_vec(), exp_vec());
            end
        end
        vectors++;
        if (b_rptr !== 4'd15 || g_rptr !== 4'b1000) begin
            miscompares++;
            $display("FAIL wrap_at15: got b=%h g=%b required b=f g=1000", b_rptr, g_rptr);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        r_en = 1; wp = 4'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (act_vec() !== exp_vec() || b_rptr !== 4'(i) || g_rptr !== 4'(i)) begin
                miscompares++;
                $display("FAIL wrap_cross[%0d]: got %h required %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full_depth();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 8);
        tick();
        vectors++;
        if (act_vec() !== exp_vec() || rd_count !== 4'd8 || empty !== 1'b0 || almost_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL full_depth: got %h required %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_flush();
        r_en = 1;
        repeat (3) tick();
        vectors++;
        if (rd_count !== 4'd5 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL pre_flush: got %h required %h", act_vec(), exp_vec());
        end
        flush = 1;
        tick();
        flush = 0; r_en = 0;
        vectors++;
        if (act_vec() !== exp_vec() || b_rptr !== 4'd8 || empty !== 1'b1 || rd_count !== 4'd0 ||
            almost_empty !== 1'b1 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: got %h required %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_underflow_clear();
        bit exp_uf [3] = '{1'b1, 1'b1, 1'b0};
        bit rr     [3] = '{1'b1, 1'b1, 1'b0};
        bit cc     [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            r_en = rr[i]; clr_err = cc[i];
            tick();
            vectors++;
            if (underflow !== exp_uf[i] || act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL uf_clear[%0d]: got %h required %h", i, act_vec(), exp_vec());
            end
        end
        clr_err = 0;
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 0, (m_rp + 5) % MOD);
        tick();
        r_en = 1;
        repeat (2) tick();
        vectors++;
        if (rd_count !== 4'd3 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL pre_reset_mid: got %h required %h", act_vec(), exp_vec());
        end
        arst = 1; clr_err = 1;
        tick();
        vectors++;
        if (act_vec() !== 18'b0000_0000_000_1_1_0000_0 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_mid: got %h required %h", act_vec(), exp_vec());
        end
        set_in(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int occ;
        int add;
        for (int i = 0; i < 600; i++) begin
            occ = (int'(wp) - m_rp + MOD) % MOD;
            add = $urandom_range(0, 2);
            if (occ + add > DEPTH) add = DEPTH - occ;
            wp      = 4'((int'(wp) + add) % MOD);
            r_en    = ($urandom_range(0, 99) < 60);
            flush   = ($urandom_range(0, 99) < 4);
            clr_err = ($urandom_range(0, 99) < 10);
            arst    = ($urandom_range(0, 199) == 0);
            tick();
            if (arst) wp = '0;
            vectors++;
            if (act_vec() !== exp_vec() || rd_count > 4'(DEPTH)) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h required %h", i, act_vec(), exp_vec());
            end
        end
        set_in(0, 0, 0, 0, int'(wp));
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0);
        m_rp = 0; m_count = 0; m_empty = 1; m_ae = 1; m_uf = 0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_depth();
        test_flush();
        test_underflow_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
